count4_seq: RTL and testbench

Command sequencer placed directly upstream of the 4-bit loadable up/down counter. It drives the counter's `set`, `set_count` and `dec` controls so that the counter runs from a commanded start value to a stop value, then parks there. It can also sweep back and forth between the two values until aborted. The block tracks the expected counter value internally and can optionally check it against the counter's `count` output.

---
 rtl/count4_pkg.sv | 20 ++
 rtl/count4_seq_if.sv | 28 ++
 rtl/count4_seq.sv | 182 ++++++++++++++++++
 tb/tb_count4_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/count4_pkg.sv
// rtl/count4_pkg.sv - shared types and constants for the 4-bit counter sequencer
package count4_pkg;

    localparam int CNT_W = 4;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    // One counter step in the given direction; mirrors the downstream counter.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] v, input logic dn);
        return (dn == DIR_DN) ? v - CNT_W'(1) : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/count4_seq_if.sv
// rtl/count4_seq_if.sv - command, counter-control and status bundle for count4_seq
interface count4_seq_if;
    import count4_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_start;
    logic [CNT_W-1:0] cmd_stop;
    logic             cmd_bounce;
    logic             abort;
    logic             set;
    logic [CNT_W-1:0] set_count;
    logic             dec;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_start, cmd_stop, cmd_bounce, abort, count,
        input  cmd_ready, set, set_count, dec, done, err
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_stop, cmd_bounce, abort, count,
        output cmd_ready, set, set_count, dec, done, err
    );

endinterface

// File: rtl/count4_seq.sv
// rtl/count4_seq.sv - drives a loadable up/down counter from start to stop (one-shot or bounce)
// Optional count-vs-expected checking is enabled by COUNT4_SEQ_CHECK_EN.
module count4_seq
    import count4_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    count4_seq_if.slave bus
);

    state_e           state_q, state_d;
    logic             set_q, set_d;
    logic [CNT_W-1:0] set_count_q, set_count_d;
    logic             dec_q, dec_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] park_q, park_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] start_q, start_d;
    logic [CNT_W-1:0] stop_q, stop_d;
    logic [CNT_W-1:0] dist_q, dist_d;
    logic             dn_q, dn_d;
    logic             bounce_q, bounce_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic             hs;
    logic             cmd_dn;
    logic [CNT_W-1:0] cmd_dist;
    logic [CNT_W-1:0] exp_step;

    assign hs       = bus.cmd_valid && ready_q;
    assign cmd_dn   = (bus.cmd_stop < bus.cmd_start) ? DIR_DN : DIR_UP;
    assign cmd_dist = (cmd_dn == DIR_DN) ? bus.cmd_start - bus.cmd_stop
                                         : bus.cmd_stop - bus.cmd_start;
    assign exp_step = cnt_step(exp_q, dec_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            set_q       <= 1'b1;
            set_count_q <= '0;
            dec_q       <= DIR_UP;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            park_q      <= '0;
            exp_q       <= '0;
            armed_q     <= 1'b0;
            start_q     <= '0;
            stop_q      <= '0;
            dist_q      <= '0;
            dn_q        <= DIR_UP;
            bounce_q    <= 1'b0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            set_count_q <= set_count_d;
            dec_q       <= dec_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            park_q      <= park_d;
            exp_q       <= exp_d;
            armed_q     <= armed_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            dist_q      <= dist_d;
            dn_q        <= dn_d;
            bounce_q    <= bounce_d;
            rem_q       <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = LOAD;
            LOAD:    state_d = (dist_q == '0) ? IDLE : RUN;
            RUN: begin
                if (bus.abort)
                    state_d = IDLE;
                else if (rem_q == CNT_W'(1) && !bounce_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        set_d       = set_q;
        set_count_d = set_count_q;
        dec_d       = dec_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        park_d      = park_q;
        exp_d       = exp_q;
        armed_d     = armed_q;
        start_d     = start_q;
        stop_d      = stop_q;
        dist_d      = dist_q;
        dn_d        = dn_q;
        bounce_d    = bounce_q;
        rem_d       = rem_q;
        case (state_q)
            IDLE: begin
                set_d       = 1'b1;
                set_count_d = park_q;
                ready_d     = 1'b1;
                if (hs) begin
                    start_d     = bus.cmd_start;
                    stop_d      = bus.cmd_stop;
                    dist_d      = cmd_dist;
                    dn_d        = cmd_dn;
                    bounce_d    = bus.cmd_bounce;
                    set_count_d = bus.cmd_start;
                    ready_d     = 1'b0;
                end
            end
            LOAD: begin
                exp_d   = start_q;
                armed_d = 1'b1;
                if (dist_q == '0) begin
                    done_d      = 1'b1;
                    park_d      = stop_q;
                    set_count_d = stop_q;
                    ready_d     = 1'b1;
                end else begin
                    set_d = 1'b0;
                    dec_d = dn_q;
                    rem_d = dist_q;
                end
            end
            RUN: begin
                exp_d = exp_step;
                // Abort freezes the counter at the value it takes on this same edge.
                if (bus.abort) begin
                    set_d       = 1'b1;
                    set_count_d = exp_step;
                    park_d      = exp_step;
                    done_d      = 1'b1;
                    ready_d     = 1'b1;
                end else if (rem_q == CNT_W'(1)) begin
                    if (!bounce_q) begin
                        set_d       = 1'b1;
                        set_count_d = stop_q;
                        park_d      = stop_q;
                        done_d      = 1'b1;
                        ready_d     = 1'b1;
                    end else begin
                        dn_d  = ~dn_q;
                        dec_d = ~dn_q;
                        rem_d = dist_q;
                    end
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

`ifdef COUNT4_SEQ_CHECK_EN
    logic [CNT_W-1:0] ref_val;
    assign ref_val = (state_q == IDLE) ? park_q : exp_q;
    assign err_d   = err_q | (armed_q && (bus.count != ref_val));
`else
    logic unused_chk;
    assign unused_chk = ^{bus.count, armed_q, err_q};
    assign err_d      = 1'b0;
`endif

    assign bus.cmd_ready = ready_q;
    assign bus.set       = set_q;
    assign bus.set_count = set_count_q;
    assign bus.dec       = dec_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_count4_seq.sv
// tb/tb_count4_seq.sv - directed closed-loop bench: count4_seq driving a behavioural 4-bit counter
module tb_count4_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt = 4'd0;
    logic       glitch = 1'b0;
    int         checks = 0;
    int         errors = 0;

`ifdef COUNT4_SEQ_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    count4_seq_if bus ();

    count4_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.set)
            cnt <= bus.set_count;
        else if (bus.dec)
            cnt <= cnt - 4'd1;
        else
            cnt <= cnt + 4'd1;
    end

    assign bus.count = cnt ^ {3'b000, glitch};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] e, input logic b);
        bus.cmd_valid  = 1'b1;
        bus.cmd_start  = s;
        bus.cmd_stop   = e;
        bus.cmd_bounce = b;
        step();
        bus.cmd_valid  = 1'b0;
    endtask

    initial begin
        logic [3:0] bseq [6];
        bseq = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd2};
        bus.cmd_valid  = 1'b0;
        bus.cmd_start  = 4'd0;
        bus.cmd_stop   = 4'd0;
        bus.cmd_bounce = 1'b0;
        bus.abort      = 1'b0;

        step();
        step();
        reset = 1'b0;
        check("rst_set", bus.set, 1);
        check("rst_set_count", bus.set_count, 0);
        check("rst_dec", bus.dec, 0);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_cnt", cnt, 0);

        // one-shot up 3 -> 7
        send(4'd3, 4'd7, 1'b0);
        check("up_ready_low", bus.cmd_ready, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("up_cnt", cnt, 32'(2 + k));
            check("up_done", bus.done, (k == 5) ? 1 : 0);
        end
        step();
        check("up_hold", cnt, 7);
        check("up_done_gone", bus.done, 0);
        step();
        check("up_hold2", cnt, 7);
        check("up_err", bus.err, 0);

        // one-shot down 9 -> 2
        send(4'd9, 4'd2, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("dn_cnt", cnt, 32'(10 - k));
            check("dn_done", bus.done, (k == 8) ? 1 : 0);
            if (k == 4) check("dn_dec", bus.dec, 1);
        end
        step();
        check("dn_hold", cnt, 2);

        // zero-distance 5 -> 5
        send(4'd5, 4'd5, 1'b0);
        check("z_set0", bus.set, 1);
        step();
        check("z_cnt", cnt, 5);
        check("z_done", bus.done, 1);
        check("z_set1", bus.set, 1);
        step();
        check("z_hold", cnt, 5);
        check("z_done_gone", bus.done, 0);
        check("z_set2", bus.set, 1);

        // bounce 1 <-> 3, abort while rising through 2
        send(4'd1, 4'd3, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("b_cnt", cnt, 32'(bseq[k-1]));
            check("b_done", bus.done, 0);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("ab_cnt", cnt, 3);
        check("ab_done", bus.done, 1);
        check("ab_set", bus.set, 1);
        step();
        check("ab_hold", cnt, 3);
        check("ab_done_gone", bus.done, 0);

        // abort in IDLE is ignored
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("idle_ab_done", bus.done, 0);
        check("idle_ab_ready", bus.cmd_ready, 1);
        check("idle_ab_cnt", cnt, 3);

        // back-to-back: cmd_valid held, second command taken in the done cycle
        bus.cmd_valid  = 1'b1;
        bus.cmd_start  = 4'd2;
        bus.cmd_stop   = 4'd4;
        bus.cmd_bounce = 1'b0;
        step();
        step();
        check("bb_cnt0", cnt, 2);
        step();
        step();
        check("bb_cnt2", cnt, 4);
        check("bb_done", bus.done, 1);
        check("bb_ready", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        check("bb_reaccept", bus.cmd_ready, 0);
        step();
        check("bb_reload", cnt, 2);
        step();
        step();
        check("bb_done2", bus.done, 1);

        // 0 -> 15 with abort in IDLE/LOAD, cmd_valid in RUN, then reset mid-run
        bus.abort = 1'b1;
        send(4'd0, 4'd15, 1'b0);
        step();
        bus.abort = 1'b0;
        check("r_load_cnt", cnt, 0);
        check("r_running", bus.set, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_start = 4'd9;
        bus.cmd_stop  = 4'd9;
        step();
        step();
        bus.cmd_valid = 1'b0;
        check("r_ignore_cmd", cnt, 2);
        step();
        step();
        check("r_cnt4", cnt, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_set", bus.set, 1);
        check("mr_set_count", bus.set_count, 0);
        check("mr_dec", bus.dec, 0);
        check("mr_ready", bus.cmd_ready, 1);
        check("mr_done", bus.done, 0);
        check("mr_err", bus.err, 0);
        step();
        check("mr_cnt", cnt, 0);
        check("mr_done2", bus.done, 0);

        // one-cycle count corruption during RUN
        send(4'd0, 4'd3, 1'b0);
        step();
        step();
        glitch = 1'b1;
        step();
        glitch = 1'b0;
        check("e_err", bus.err, 32'(ERR_EXP));
        step();
        check("e_done", bus.done, 1);
        check("e_sticky", bus.err, 32'(ERR_EXP));
        step();
        check("e_sticky2", bus.err, 32'(ERR_EXP));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("e_cleared", bus.err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
